// File: rtl/zmips_pkg.sv
// Shared types and constants for the zmips data memory.
package zmips_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_BOTH  = 2'd1;
    localparam logic [1:0] ERR_ALIGN = 2'd2;
    localparam logic [1:0] ERR_RANGE = 2'd3;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/zmips_dmem_if.sv
// zmips data-port bus: the core is the master, the data memory the slave.
interface zmips_dmem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   d_addr;
    logic [DATA_W-1:0]   d_data_o;
    logic [DATA_W/8-1:0] d_be;
    logic                d_wr;
    logic                d_rd;
    logic [DATA_W-1:0]   d_data_i;
    logic                d_ready;
    logic                d_err;

    modport master (
        output d_addr, d_data_o, d_be, d_wr, d_rd,
        input  d_data_i, d_ready, d_err
    );

    modport slave (
        input  d_addr, d_data_o, d_be, d_wr, d_rd,
        output d_data_i, d_ready, d_err
    );
endinterface

// File: rtl/zmips_dmem_array.sv
// Synchronous word array, per-byte write enable, one registered read port.
// Kept free of reset so it maps onto a vendor block RAM.
module zmips_dmem_array
    import zmips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    localparam int IDX_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
    localparam int NB    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [NB-1:0]     be,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/zmips_dmem.sv
// zmips data memory: request/ready handshake, configurable wait states,
// byte-lane writes, error response on misaligned/out-of-range/rd+wr.
module zmips_dmem
    import zmips_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 4096,
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    zmips_dmem_if.slave  bus
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF   = clog2(NB);
    localparam int IDX_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
    localparam logic [ADDR_W-1:0] OFF_MASK = (ADDR_W'(1) << OFF) - ADDR_W'(1);
    localparam logic [3:0] WS_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    dmem_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NB-1:0]     be_q, be_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [1:0]        cause_q, cause_d;
    logic              zero_q, zero_d;

    logic              req;
    logic [1:0]        in_cause;
    logic              enter_resp;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_rd;
    logic [1:0]        cur_cause;
    logic              arr_we, arr_re;
    logic [DATA_W-1:0] arr_rdata;

    assign req = bus.d_rd | bus.d_wr;

    always_comb begin
        in_cause = ERR_NONE;
        if (bus.d_rd && bus.d_wr)                          in_cause = ERR_BOTH;
        else if ((bus.d_addr & OFF_MASK) != '0)            in_cause = ERR_ALIGN;
        else if (((bus.d_addr >> OFF) >> IDX_W) != '0)     in_cause = ERR_RANGE;
    end

    // With no wait states the array is read straight from the bus on the
    // accepting edge; otherwise from the captured request.
    assign enter_resp = (state_q == IDLE && req && WAIT_STATES == 0) ||
                        (state_q == WAIT && cnt_q == 4'd0);
    assign cur_addr  = (state_q == IDLE) ? bus.d_addr : addr_q;
    assign cur_rd    = (state_q == IDLE) ? bus.d_rd   : rd_q;
    assign cur_cause = (state_q == IDLE) ? in_cause   : cause_q;

    assign arr_re = enter_resp && cur_rd && (cur_cause == ERR_NONE);
    assign arr_we = (state_q == RESP) && wr_q && (cause_q == ERR_NONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cause_d = cause_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = bus.d_addr;
                    wdata_d = bus.d_data_o;
                    be_d    = bus.d_be;
                    rd_d    = bus.d_rd;
                    wr_d    = bus.d_wr;
                    cause_d = in_cause;
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WS_INIT;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Error responses force zero read data; writes leave the last read visible.
        if (enter_resp) begin
            if (cur_cause != ERR_NONE) zero_d = 1'b1;
            else if (cur_rd)           zero_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            cause_q <= ERR_NONE;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cause_q <= cause_d;
            zero_q  <= zero_d;
        end
    end

    zmips_dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (IDX_W'(addr_q >> OFF)),
        .wdata (wdata_q),
        .be    (be_q),
        .re    (arr_re),
        .raddr (IDX_W'(cur_addr >> OFF)),
        .rdata (arr_rdata)
    );

    assign bus.d_ready  = (state_q == RESP);
    assign bus.d_err    = (state_q == RESP) && (cause_q != ERR_NONE);
    assign bus.d_data_i = zero_q ? '0 : arr_rdata;

endmodule

// File: doc/zmips_dmem.md
# zmips_dmem

Parametrised data memory for the zmips core. It replaces the bench-level combinational data array with a clocked memory that has configurable width, depth and wait states, byte-lane writes, and a request/ready handshake. Misaligned and out-of-range accesses return an error response. It sits on the zmips data port (`d_addr`, `d_data_o`, `d_data_i`, `d_wr`, `d_rd`) and is used both in the bench and in synthesis.

## Interface
- `DATA_W`, default 32: data width in bits; a multiple of 8, at least 8.
- `DEPTH`, default 4096: number of words; a power of two.
- `WAIT_STATES`, default 0: extra cycles before the response, range 0..15.
- `ADDR_W`, default 32: byte-address width.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `d_addr`  in  ADDR_W: byte address.
- `d_data_o`  in  DATA_W: write data from the core.
- `d_be`  in  DATA_W/8: byte-lane enables for writes; ignored on reads.
- `d_wr`  in  1: write request.
- `d_rd`  in  1: read request.
- `d_data_i`  out  DATA_W: registered read data to the core.
- `d_ready`  out  1: one-cycle response strobe.
- `d_err`  out  1: error qualifier; valid only while `d_ready`=1.

## Operation
- Word index is `d_addr >> log2(DATA_W/8)`.
- An access is misaligned if `d_addr[log2(DATA_W/8)-1:0]` is not 0.
- An access is out of range if the word index is greater than or equal to DEPTH.
- FSM states:
  - IDLE: accept a request.
  - WAIT: count down the wait states.
  - RESP: drive the response.
- IDLE → WAIT when `d_rd|d_wr`=1 and WAIT_STATES>0.
- IDLE → RESP when `d_rd|d_wr`=1 and WAIT_STATES=0.
- WAIT → RESP when the counter reaches 0. RESP → IDLE unconditionally.
- On acceptance the block captures address, write data, `d_be`, and the kind of access. Input changes after capture are ignored until the block is back in IDLE.
- Error cases:
  - `d_rd` and `d_wr` both high: error response, no memory change.
  - Misaligned or out of range: error response, no write; `d_data_i` is all zeros.
- Write: on the RESP edge, each byte lane *i* with `d_be[i]`=1 is updated. `d_be`=0 gives a successful no-op.
- Read: `d_data_i` is loaded with `mem[index]` on the edge that enters RESP and holds that value until the next read response.
- Memory contents are not reset. Simulation initialises them to X unless they are preloaded.

## Timing
- Reset values: `d_ready`=0, `d_err`=0, `d_data_i`=0, FSM in IDLE, counter 0.
- Latency: a request sampled at edge N gives `d_ready`=1 during cycle N+1+WAIT_STATES.
- `d_ready` is high for exactly one cycle.
- The core holds `d_rd`/`d_wr` until it sees `d_ready`. It must deassert them, or present a new request, in the cycle after `d_ready`. The block takes no new request while in RESP.
- Throughput: at most one access every 2+WAIT_STATES cycles.
- Write commit happens on the edge that ends the RESP cycle. A read issued after that edge returns the new data; there is no bypass.
- Reset asserted mid-access returns to IDLE immediately. An uncommitted write is dropped, and the outputs go to their reset values asynchronously.
- Simultaneous release of `rst_n` and a request: the request is first sampled on the next rising edge after release.

## Structure
- Package `zmips_pkg` holds:
  - enum `dmem_state_t` {IDLE, WAIT, RESP};
  - `localparam` function `clog2`;
  - the error-cause constants.
- Sub-module `zmips_dmem_array`: a synchronous word array with per-byte write enable and one read port, so it can be swapped for a vendor RAM.
- The FSM, counter, and range/alignment checks live in `zmips_dmem`.

## Test plan
- Reset with WAIT_STATES=0: write 0xDEADBEEF to 0x10 with `d_be`=4'hF, then read 0x10 → `d_ready` one cycle after each request; read returns 0xDEADBEEF, `d_err`=0.
- Byte lanes: word 0x20 = 0x11223344; write 0xAABBCCDD with `d_be`=4'b0101 → read returns 0x11BB33DD.
- WAIT_STATES=3: read request at edge N → `d_ready` only in cycle N+4; toggling `d_addr` during WAIT has no effect.
- Errors:
  - read 0x0002 → `d_err`=1, `d_data_i`=0;
  - write to byte address 4*DEPTH → `d_err`=1 and word 0 is unchanged;
  - `d_rd`=`d_wr`=1 → `d_err`=1.
- Reset mid-access: WAIT_STATES=5, write 0xCAFEF00D to 0x40, pull `rst_n` low in WAIT → `d_ready`=0 at once, then a read of 0x40 returns its old value.
- Back-to-back: write 0x1 to 0x8, then read 0x8 immediately after `d_ready` → read returns 0x1; no request is accepted during the RESP cycle.
